// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared constants and helpers for the input_debouncer slice.
//   - DB_TICK_DIV_DEF     : default clk cycles per sample tick
//   - DB_STABLE_TICKS_DEF : default number of ticks an input must hold a new value
//   - clog2()             : ceiling log2, used to size the prescaler and stability counters
//   No ports; imported with import debounce_pkg::*.
package debounce_pkg;

  localparam int DB_TICK_DIV_DEF     = 50000;
  localparam int DB_STABLE_TICKS_DEF = 4;

  // Smallest n with 2**n >= value; returns 0 for value <= 1, so callers that
  // need a register must clamp the result to at least one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One-bit debounce filter. Follows an already-synchronised input and only
//   changes its output level after the input has disagreed with it on
//   STABLE_TICKS consecutive sample ticks without ever agreeing in between.
//   Optionally registers one-cycle rise/fall pulses aligned with the level change.
//
//   Ports:
//     clk    in   system clock
//     rst    in   synchronous, active-high reset
//     s      in   synchronised input bit
//     tick   in   shared sample strobe from the prescaler
//     level  out  debounced level
//     rise   out  one-cycle pulse when level goes 0->1
//     fall   out  one-cycle pulse when level goes 1->0
//
//   Configuration macro: INPUT_DEBOUNCE_EDGE_EN
//     defined   -> rise/fall registers are built
//     undefined -> rise/fall are tied to 0 and no registers are built
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DB_STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (clog2(STABLE_TICKS + 1) < 1) ? 1 : clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             w_differs;
  logic             w_flip;

  // The level flips on the tick that completes the stability window.
  assign w_differs = (s != r_level);
  assign w_flip    = w_differs && tick && (r_cnt == CNT_LAST);

  // Stability counter and output level. Any cycle where the input agrees with
  // the output throws away the progress, tick or not, so bounce never
  // accumulates across separate glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (!w_differs) begin
      r_cnt <= '0;
    end else if (w_flip) begin
      r_level <= s;
      r_cnt   <= '0;
    end else if (tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign level = r_level;

`ifdef INPUT_DEBOUNCE_EDGE_EN
  logic r_rise;
  logic r_fall;

  // Pulses are registered on the same edge as the level update, so they are
  // high exactly in the cycle the new level is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_flip &  s;
      r_fall <= w_flip & ~s;
    end
  end

  assign rise = r_rise;
  assign fall = r_fall;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer
//   Conditions raw switch/button inputs before the encoder and display logic.
//   Each bit is passed through a 2-FF synchroniser, then filtered by its own
//   debounce_channel. All channels share one sample-tick prescaler.
//
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous, active-high reset
//     din      in   WIDTH raw asynchronous inputs
//     dout     out  WIDTH debounced levels
//     rise     out  WIDTH one-cycle pulses on dout 0->1
//     fall     out  WIDTH one-cycle pulses on dout 1->0
//     changed  out  OR of all rise|fall bits, same cycle
//
//   Parameters:
//     WIDTH         number of independent channels
//     TICK_DIV      clk cycles per sample tick (1 = tick every cycle)
//     STABLE_TICKS  consecutive disagreeing ticks needed to flip an output
//
//   Configuration macro: INPUT_DEBOUNCE_EDGE_EN
//     defined   -> rise/fall/changed are live
//     undefined -> rise/fall/changed are constant 0; dout timing is unchanged
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int TICK_DIV     = DB_TICK_DIV_DEF,
  parameter int STABLE_TICKS = DB_STABLE_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] r_syncStage1;
  logic [WIDTH-1:0] r_syncStage2;
  logic             w_tick;

  // Two-stage synchroniser; the second stage is the only view of din the
  // filters ever see. Reset clears it so no stale value survives a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_syncStage1 <= '0;
      r_syncStage2 <= '0;
    end else begin
      r_syncStage1 <= din;
      r_syncStage2 <= r_syncStage1;
    end
  end

  generate
    if (TICK_DIV <= 1) begin : g_tickAlways
      assign w_tick = 1'b1;
    end else begin : g_prescaler
      localparam int PRE_W = clog2(TICK_DIV);
      localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

      logic [PRE_W-1:0] r_pre;

      // Free-running 0..TICK_DIV-1 counter; the tick is its terminal count.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pre <= '0;
        end else if (r_pre == PRE_LAST) begin
          r_pre <= '0;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end

      assign w_tick = (r_pre == PRE_LAST);
    end
  endgenerate

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_channel
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_channel (
      .clk  (clk),
      .rst  (rst),
      .s    (r_syncStage2[gi]),
      .tick (w_tick),
      .level(dout[gi]),
      .rise (rise[gi]),
      .fall (fall[gi])
    );
  end

`ifdef INPUT_DEBOUNCE_EDGE_EN
  assign changed = |(rise | fall);
`else
  assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer
//   Directed bench for input_debouncer. Main instance uses TICK_DIV=4,
//   STABLE_TICKS=3; a second instance uses TICK_DIV=1, STABLE_TICKS=1.
//   Pulse expectations are masked to zero when INPUT_DEBOUNCE_EDGE_EN is
//   not defined, so the same bench covers both builds.
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCE_EDGE_EN
  localparam logic [15:0] EDGE_MASK = 16'hFFFF;
`else
  localparam logic [15:0] EDGE_MASK = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = 16'hFFFF;
  logic [15:0] dout;
  logic [15:0] rise;
  logic [15:0] fall;
  logic        changed;

  logic [15:0] din6 = 16'h0000;
  logic [15:0] dout6;
  logic [15:0] rise6;
  logic [15:0] fall6;
  logic        changed6;

  int checks   = 0;
  int failures = 0;

  input_debouncer #(
    .WIDTH(16), .TICK_DIV(4), .STABLE_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout),
    .rise(rise), .fall(fall), .changed(changed)
  );

  input_debouncer #(
    .WIDTH(16), .TICK_DIV(1), .STABLE_TICKS(1)
  ) dutFast (
    .clk(clk), .rst(rst), .din(din6), .dout(dout6),
    .rise(rise6), .fall(fall6), .changed(changed6)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] din;
    int          adv;
    logic [15:0] expDout;
    logic [15:0] expRise;
    logic [15:0] expFall;
    logic        expChanged;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Advance n clock edges, leaving time 1 unit past the last edge.
  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] value, input int n);
    din = value;
    stepCycles(n);
  endtask

  // Two reset edges; on return the next edge is the first non-reset edge (R1).
  task automatic doReset(input logic [15:0] value);
    rst = 1'b1;
    din = value;
    stepCycles(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int latency;
    int riseCount;
    int fallCount;
    logic changedAtFlip;
    logic riseAtFlip;
    logic earlyFlip;

    // Test 1: reset with all inputs high
    rst = 1'b1;
    din = 16'hFFFF;
    stepCycles(1);
    checkOutput("t1 dout in reset", dout, 16'h0000);
    checkOutput("t1 rise in reset", rise, 16'h0000);
    stepCycles(1);
    checkOutput("t1 fall in reset", fall, 16'h0000);
    checkOutput("t1 changed in reset", {15'b0, changed}, 16'h0000);
    rst = 1'b0;
    stepCycles(1);
    checkOutput("t1 dout after reset", dout, 16'h0000);
    checkOutput("t1 rise after reset", rise, 16'h0000);
    checkOutput("t1 changed after reset", {15'b0, changed}, 16'h0000);

    // Tests 3/5: vector table, ticks land on edges R4, R8, R12, ...
    vecs.push_back('{"t5 before rise",   16'h00FF, 11, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{"t5 rise cycle",    16'h00FF,  1, 16'h00FF, 16'h00FF, 16'h0000, 1'b1});
    vecs.push_back('{"t5 after rise",    16'h00FF,  1, 16'h00FF, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{"t5 before fall",   16'h0000, 10, 16'h00FF, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{"t5 fall cycle",    16'h0000,  1, 16'h0000, 16'h0000, 16'h00FF, 1'b1});
    vecs.push_back('{"t5 after fall",    16'h0000,  1, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{"t3 glitch1 high",  16'h0008,  6, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{"t3 glitch1 after", 16'h0000, 20, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{"t3 glitch2 high",  16'h0008,  6, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{"t3 glitch2 after", 16'h0000, 10, 16'h0000, 16'h0000, 16'h0000, 1'b0});

    doReset(16'h0000);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].din, vecs[i].adv);
      checkOutput({vecs[i].name, " dout"}, dout, vecs[i].expDout);
      checkOutput({vecs[i].name, " rise"}, rise, vecs[i].expRise & EDGE_MASK);
      checkOutput({vecs[i].name, " fall"}, fall, vecs[i].expFall & EDGE_MASK);
      checkOutput({vecs[i].name, " changed"}, {15'b0, changed},
                  {15'b0, vecs[i].expChanged & EDGE_MASK[0]});
    end

    // Test 2 (and 8 in the non-edge build): single step on din[0]
    doReset(16'h0000);
    applyStimulus(16'h0000, 1);
    din = 16'h0001;
    latency = 0;
    riseCount = 0;
    fallCount = 0;
    changedAtFlip = 1'b0;
    riseAtFlip = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      stepCycles(1);
      if (dout[0] && latency == 0) begin
        latency = i;
        changedAtFlip = changed;
        riseAtFlip = rise[0];
      end
      if (rise[0]) riseCount++;
      if (fall[0]) fallCount++;
    end
    checkRange("t2 latency", latency, 11, 14);
    checkOutput("t2 rise at flip", {15'b0, riseAtFlip}, {15'b0, EDGE_MASK[0]});
    checkOutput("t2 changed at flip", {15'b0, changedAtFlip}, {15'b0, EDGE_MASK[0]});
    checkRange("t2 rise count", riseCount, int'(EDGE_MASK[0]), int'(EDGE_MASK[0]));
    checkRange("t2 fall count", fallCount, 0, 0);
    checkOutput("t2 dout final", dout, 16'h0001);

    // Test 4: din[5] toggles every 2 cycles for 40 cycles, then held high
    doReset(16'h0000);
    earlyFlip = 1'b0;
    riseCount = 0;
    fallCount = 0;
    for (int c = 0; c < 40; c++) begin
      din = ((c / 2) % 2 == 0) ? 16'h0020 : 16'h0000;
      stepCycles(1);
      if (dout[5]) earlyFlip = 1'b1;
      if (rise[5]) riseCount++;
      if (fall[5]) fallCount++;
    end
    checkOutput("t4 no flip while toggling", {15'b0, earlyFlip}, 16'h0000);
    din = 16'h0020;
    for (int c = 0; c < 30; c++) begin
      stepCycles(1);
      if (rise[5]) riseCount++;
      if (fall[5]) fallCount++;
    end
    checkOutput("t4 dout after hold", dout, 16'h0020);
    checkRange("t4 rise count", riseCount, int'(EDGE_MASK[0]), int'(EDGE_MASK[0]));
    checkRange("t4 fall count", fallCount, 0, 0);

    // Test 7: reset after two of three ticks have counted
    doReset(16'h0000);
    applyStimulus(16'h0004, 10);
    checkOutput("t7 dout mid-count", dout, 16'h0000);
    rst = 1'b1;
    stepCycles(1);
    checkOutput("t7 dout on reset edge", dout, 16'h0000);
    checkOutput("t7 rise on reset edge", rise, 16'h0000);
    rst = 1'b0;
    stepCycles(11);
    checkOutput("t7 dout before new window", dout, 16'h0000);
    stepCycles(1);
    checkOutput("t7 dout after new window", dout, 16'h0004);
    checkOutput("t7 rise after new window", rise, 16'h0004 & EDGE_MASK);
    stepCycles(1);
    checkOutput("t7 rise cleared", rise, 16'h0000);

    // Test 6: TICK_DIV=1, STABLE_TICKS=1 gives exactly 3 cycles latency
    din6 = 16'h0080;
    stepCycles(2);
    checkOutput("t6 dout at 2 cycles", dout6, 16'h0000);
    stepCycles(1);
    checkOutput("t6 dout at 3 cycles", dout6, 16'h0080);
    checkOutput("t6 rise at 3 cycles", rise6, 16'h0080 & EDGE_MASK);
    checkOutput("t6 changed at 3 cycles", {15'b0, changed6}, {15'b0, EDGE_MASK[0]});
    stepCycles(1);
    checkOutput("t6 rise cleared", rise6, 16'h0000);
    din6 = 16'h0000;
    stepCycles(2);
    checkOutput("t6 dout hold before fall", dout6, 16'h0080);
    stepCycles(1);
    checkOutput("t6 dout fall at 3 cycles", dout6, 16'h0000);
    checkOutput("t6 fall at 3 cycles", fall6, 16'h0080 & EDGE_MASK);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
